iir_sample_feeder: RTL

Upstream source for the IIR filter's sample input. Accepts samples over a valid/ready stream, buffers them in a small FIFO, and issues them to the IIR one at a time as a single-cycle `newDataAvailable` strobe with `newData`. Holds off the next sample until the IIR pulses `done`, so a slow filter configuration (few multipliers per cycle) never loses data. Sits between the ADC/sample front end and the IIR's `newData`/`newDataAvailable` inputs.

---
 rtl/iir_pkg.sv | 17 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/iir_sample_feeder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/iir_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iir_pkg : shared IIR definitions (sample width, feeder FSM states)
// Rev 1.0
// ---------------------------------------------------------------------------
package iir_pkg;

  localparam int IIR_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with head-of-queue read and synchronous flush
// Rev 1.0
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [DATA_WIDTH-1:0]      i_data,
  output logic [DATA_WIDTH-1:0]      o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_push;
  logic                  w_pop;

  // Guard against overflow/underflow here so callers cannot corrupt the count.
  assign w_push  = i_push && !o_full  && !i_flush;
  assign w_pop   = i_pop  && !o_empty && !i_flush;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/iir_sample_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iir_sample_feeder : buffers stream samples and issues them one at a time to
// the IIR, waiting for done. Optional IIR_FEEDER_TIMEOUT_EN adds a done timeout.
// Rev 1.0
// ---------------------------------------------------------------------------
module iir_sample_feeder
  import iir_pkg::*;
#(
  parameter int DATA_WIDTH = IIR_DATA_WIDTH,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       done,
  output logic [DATA_WIDTH-1:0]      newData,
  output logic                       newDataAvailable,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       busy
`ifdef IIR_FEEDER_TIMEOUT_EN
  ,
  output logic                       timeout_err
`endif
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_check
    $error("iir_sample_feeder: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  feeder_state_t         r_state;
  feeder_state_t         w_next;
  logic                  w_load;
  logic                  w_done_eff;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] r_new_data;
  logic                  r_nda;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .i_push  (in_valid && !w_full),
    .i_pop   (r_state == ISSUE),
    .i_flush (flush),
    .i_data  (in_data),
    .o_head  (w_head),
    .o_count (fill_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef IIR_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_to_err;
  logic          w_timeout;

  // Fires on the TIMEOUT-th WAIT_DONE cycle, so the forced strobe lands TIMEOUT
  // cycles after WAIT_DONE was entered.
  assign w_timeout   = (r_state == WAIT_DONE) && (r_to_cnt == TW'(TIMEOUT - 1));
  assign w_done_eff  = done || w_timeout;
  assign timeout_err = r_to_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else if (flush) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      if (r_state != WAIT_DONE) r_to_cnt <= '0;
      else                      r_to_cnt <= r_to_cnt + TW'(1);
      if (w_timeout && !done)   r_to_err <= 1'b1;
    end
  end
`else
  assign w_done_eff = done;
`endif

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_next = ISSUE;
          w_load = 1'b1;
        end
      end
      ISSUE: begin
        w_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (w_done_eff) begin
          if (!w_empty) begin
            w_next = ISSUE;
            w_load = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    if (flush) begin
      w_next = IDLE;
      w_load = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_nda      <= 1'b0;
      r_new_data <= '0;
    end else begin
      r_state <= w_next;
      r_nda   <= (w_next == ISSUE);
      if (w_load) r_new_data <= w_head;
    end
  end

  assign in_ready         = !w_full;
  assign newData          = r_new_data;
  assign newDataAvailable = r_nda;
  assign busy             = (r_state != IDLE);

endmodule
`default_nettype wire
